// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-requester SRAM arbiter: data word, FSM states and a grant helper.
// Combinational definitions only; no latency or backpressure of their own.
package Type;

    typedef logic [31:0] Data32_T;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } ArbState_T;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_select2.sv
// Two-way round-robin pick: when both requesters are valid the one that did not win last goes next.
// Purely combinational; a lone valid requester always wins.
module rr_select2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_winner
);

    always_comb begin
        o_winner = 1'b0;
        if (&i_valid) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_valid[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one single-port SRAM, one transaction in flight; write responds at t+2, read at t+3.
// Requests are held off by REQ_READY outside IDLE; responses are one-cycle strobes with no backpressure.
module sram_arbiter
    import Type::*;
#(
    parameter  int DATA_DEPTH = 8,
    localparam int AW         = $clog2(DATA_DEPTH)
) (
    input  logic            SIG_CLK,
    input  logic            SIG_RST,
    input  logic [1:0]      REQ_VALID,
    input  logic [1:0]      REQ_WR,
    input  logic [2*AW-1:0] REQ_ADDR,
    input  logic [63:0]     REQ_DATA,
    output logic [1:0]      REQ_READY,
    output logic [1:0]      RSP_VALID,
    output logic [31:0]     RSP_DATA,
    output logic            MEM_WR,
    output logic            MEM_RD,
    output logic [AW-1:0]   MEM_ADDR,
    output logic [31:0]     MEM_WDATA,
    input  logic [31:0]     MEM_RDATA,
    output logic            BUSY
);

    ArbState_T r_state;
    ArbState_T w_state_nxt;

    logic          r_last;
    logic          r_idx;
    logic          r_wr;
    logic [AW-1:0] r_addr;
    Data32_T       r_data;
    Data32_T       r_rsp_data;

    logic          w_winner;
    logic          w_accept;

    rr_select2 u_rr_select2 (
        .i_valid  (REQ_VALID),
        .i_last   (r_last),
        .o_winner (w_winner)
    );

    // Reset gates the grant combinationally so no request is accepted while it is held.
    assign w_accept = (r_state == IDLE) && (|REQ_VALID) && !SIG_RST;
    assign BUSY     = (r_state != IDLE);
    assign RSP_DATA = r_rsp_data;

    always_comb begin
        w_state_nxt = r_state;
        REQ_READY   = 2'b00;
        RSP_VALID   = 2'b00;
        MEM_WR      = 1'b0;
        MEM_RD      = 1'b0;
        MEM_ADDR    = '0;
        MEM_WDATA   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    REQ_READY   = onehot2(w_winner);
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                MEM_WR      = r_wr;
                MEM_RD      = !r_wr;
                MEM_ADDR    = r_addr;
                MEM_WDATA   = r_wr ? r_data : '0;
                w_state_nxt = r_wr ? RESP : RDWAIT;
            end
            RDWAIT: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                RSP_VALID   = onehot2(r_idx);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge SIG_CLK or posedge SIG_RST) begin
        if (SIG_RST) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_idx      <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_idx  <= w_winner;
                r_wr   <= REQ_WR[w_winner];
                r_addr <= w_winner ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0];
                r_data <= w_winner ? REQ_DATA[63:32] : REQ_DATA[31:0];
            end
            // SRAM registered its output on the edge that ended ISSUE, so it is valid now.
            if (r_state == RDWAIT) begin
                r_rsp_data <= MEM_RDATA;
            end
            if (r_state == RESP) begin
                r_last <= r_idx;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a 1-cycle-read SRAM model: vector table plus hand-written
// sequences for alternation, back-to-back reads and reset during a read.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [5:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        mem_wr;
    logic        mem_rd;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_pass;
    int n_total;

    sram_arbiter #(.DATA_DEPTH(8)) dut (
        .SIG_CLK   (clk),
        .SIG_RST   (rst),
        .REQ_VALID (req_valid),
        .REQ_WR    (req_wr),
        .REQ_ADDR  (req_addr),
        .REQ_DATA  (req_data),
        .REQ_READY (req_ready),
        .RSP_VALID (rsp_valid),
        .RSP_DATA  (rsp_data),
        .MEM_WR    (mem_wr),
        .MEM_RD    (mem_rd),
        .MEM_ADDR  (mem_addr),
        .MEM_WDATA (mem_wdata),
        .MEM_RDATA (mem_rdata),
        .BUSY      (busy)
    );

    logic [31:0] mem [8];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  wr;
        logic [2:0]  addr0;
        logic [2:0]  addr1;
        logic [31:0] data0;
        logic [31:0] data1;
        logic        winner;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [2:0] a0,
                         input logic [2:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_wr    = w;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    logic [31:0] hold_rsp;
    int          gcyc[$];
    int          gidx[$];
    logic        got;

    initial begin
        n_pass = 0;
        n_total = 0;
        hold_rsp = 32'd0;
        rst = 1'b1;
        drive(2'b11, 2'b11, 3'd1, 3'd2, 32'h11, 32'h22);

        // Reset state with both requesters valid
        @(negedge clk);
        chk("rst_ready",   {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_vld", {30'd0, rsp_valid}, 32'd0);
        chk("rst_mem_wr",  {31'd0, mem_wr},    32'd0);
        chk("rst_mem_rd",  {31'd0, mem_rd},    32'd0);
        chk("rst_mem_addr",{29'd0, mem_addr},  32'd0);
        chk("rst_mem_wdat",mem_wdata,          32'd0);
        chk("rst_rsp_dat", rsp_data,           32'd0);
        chk("rst_busy",    {31'd0, busy},      32'd0);

        // Both valid writes after reset: grants alternate 0,1,0,1, three cycles apart
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                gcyc.push_back(c);
                gidx.push_back(int'(req_ready[1]));
                chk("alt_onehot", {31'd0, ^req_ready}, 32'd1);
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        chk("alt_count", gcyc.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gcyc.size()) begin
                chk("alt_cycle", gcyc[i], 3 * i);
                chk("alt_idx",   gidx[i], i % 2);
            end
        end
        wait_idle();

        vecs[0] = '{2'b01, 2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{2'b10, 2'b00, 3'd0, 3'd3, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{2'b01, 2'b01, 3'd7, 3'd0, 32'h00000001, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{2'b01, 2'b01, 3'd0, 3'd0, 32'hA5A50000, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{2'b10, 2'b00, 3'd0, 3'd7, 32'h0, 32'h0, 1'b1, 32'h00000001};
        vecs[5] = '{2'b01, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0, 32'hA5A50000};
        vecs[6] = '{2'b11, 2'b00, 3'd0, 3'd7, 32'h0, 32'h0, 1'b1, 32'h00000001};
        vecs[7] = '{2'b11, 2'b00, 3'd0, 3'd7, 32'h0, 32'h0, 1'b0, 32'hA5A50000};

        for (int v = 0; v < 8; v++) begin
            logic       w;
            logic       is_wr;
            logic [2:0] a;
            logic [31:0] d;
            logic [1:0] oh;
            w     = vecs[v].winner;
            is_wr = vecs[v].wr[w];
            a     = w ? vecs[v].addr1 : vecs[v].addr0;
            d     = w ? vecs[v].data1 : vecs[v].data0;
            oh    = w ? 2'b10 : 2'b01;
            @(posedge clk); #1;
            drive(vecs[v].valid, vecs[v].wr, vecs[v].addr0, vecs[v].addr1,
                  vecs[v].data0, vecs[v].data1);
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                @(negedge clk);
                got = (req_ready != 2'b00);
            end
            chk("vec_grant", {30'd0, req_ready}, {30'd0, oh});
            @(posedge clk); #1 req_valid = 2'b00;
            @(negedge clk);
            chk("vec_mem_wr",   {31'd0, mem_wr},   {31'd0, is_wr});
            chk("vec_mem_rd",   {31'd0, mem_rd},   {31'd0, !is_wr});
            chk("vec_mem_addr", {29'd0, mem_addr}, {29'd0, a});
            chk("vec_mem_wdat", mem_wdata,         is_wr ? d : 32'd0);
            chk("vec_ready_busy", {30'd0, req_ready}, 32'd0);
            if (!is_wr) begin
                @(negedge clk);
                chk("vec_rdwait_rsp",  {30'd0, rsp_valid}, 32'd0);
                chk("vec_rdwait_addr", {29'd0, mem_addr},  32'd0);
                hold_rsp = vecs[v].rdata;
            end
            @(negedge clk);
            chk("vec_rsp_vld", {30'd0, rsp_valid}, {30'd0, oh});
            chk("vec_rsp_dat", rsp_data, hold_rsp);
            @(negedge clk);
            chk("vec_rsp_end", {30'd0, rsp_valid}, 32'd0);
            chk("vec_idle",    {31'd0, busy},      32'd0);
        end

        // Only req1 valid: four reads of addr 7, grants four cycles apart
        gcyc.delete();
        gidx.delete();
        @(posedge clk); #1 drive(2'b10, 2'b00, 3'd0, 3'd7, 32'h0, 32'h0);
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                gcyc.push_back(c);
                gidx.push_back(int'(req_ready[1]));
                chk("r1_no_req0", {31'd0, req_ready[0]}, 32'd0);
            end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        chk("r1_count", gcyc.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gcyc.size()) begin
                chk("r1_cycle", gcyc[i], 4 * i);
                chk("r1_idx",   gidx[i], 1);
            end
        end
        wait_idle();
        chk("r1_rsp_dat", rsp_data, 32'h00000001);

        // Reset while a req0 read sits in RDWAIT
        @(posedge clk); #1 drive(2'b01, 2'b00, 3'd3, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rr_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        chk("rr_issue_rd", {31'd0, mem_rd}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rr_rsp_vld", {30'd0, rsp_valid}, 32'd0);
        chk("rr_mem_rd",  {31'd0, mem_rd},    32'd0);
        chk("rr_busy",    {31'd0, busy},      32'd0);
        chk("rr_ready",   {30'd0, req_ready}, 32'd0);
        chk("rr_rsp_dat", rsp_data,           32'd0);
        req_valid = 2'b00;
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rr_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1 drive(2'b11, 2'b00, 3'd0, 3'd7, 32'h0, 32'h0);
        @(negedge clk);
        chk("rr_next_req0", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
